// File: rtl/tr_output_sequencer.sv
// Start/run/stop/drain sequencer for the transducer output path, aligned to TIME period boundaries.
// Optional watchdog: define TR_SEQ_WATCHDOG_EN to force a drain after WDT_PERIODS quiet boundaries.
module tr_output_sequencer #(
  parameter int ULTRASOUND_CNT_CYCLE = 512,
  parameter int ARM_PERIODS          = 2,
  parameter int DRAIN_PERIODS        = 4,
  parameter int WDT_PERIODS          = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [8:0] TIME,
  input  logic       START_REQ,
  input  logic       STOP_REQ,
  input  logic       BALANCE_REQ,
  input  logic       DATA_VALID,
  output logic       UPDATE,
  output logic       DELAY_RST,
  output logic       OUTPUT_EN,
  output logic       OUTPUT_BALANCE,
  output logic       BUSY,
  output logic [1:0] STATE,
  output logic       WDT_FLAG
);
  localparam int PMAX0 = (ARM_PERIODS > DRAIN_PERIODS) ? ARM_PERIODS : DRAIN_PERIODS;
  localparam int PMAX  = (PMAX0 > WDT_PERIODS) ? PMAX0 : WDT_PERIODS;
  localparam int PW    = $clog2(PMAX + 1);
  localparam logic [PW-1:0] ARM_LAST   = PW'(ARM_PERIODS - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_PERIODS - 1);

  typedef enum logic [1:0] {OFF = 2'd0, ARM = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

  state_t        state;
  logic [PW-1:0] pcnt, pcnt_inc;
  logic          pending, stop_pend, start_pend;
  logic          bnd, wdt_trip;

  assign bnd      = (TIME == 9'(ULTRASOUND_CNT_CYCLE - 1));
  assign pcnt_inc = (pcnt == '1) ? pcnt : pcnt + 1'b1;
  assign STATE    = state;

`ifdef TR_SEQ_WATCHDOG_EN
  localparam logic [PW-1:0] WDT_LAST = PW'(WDT_PERIODS - 1);
  // In RUN pcnt counts boundaries since the last DATA_VALID
  assign wdt_trip = bnd && !DATA_VALID && (pcnt == WDT_LAST);

  always_ff @(posedge CLK) begin
    if (RST)                          WDT_FLAG <= 1'b0;
    else if (state == RUN && wdt_trip) WDT_FLAG <= 1'b1;
    else if (START_REQ)               WDT_FLAG <= 1'b0;
  end
`else
  assign wdt_trip = 1'b0;
  assign WDT_FLAG = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= OFF;
      pcnt           <= '0;
      pending        <= 1'b0;
      stop_pend      <= 1'b0;
      start_pend     <= 1'b0;
      UPDATE         <= 1'b0;
      DELAY_RST      <= 1'b0;
      OUTPUT_EN      <= 1'b0;
      OUTPUT_BALANCE <= 1'b0;
      BUSY           <= 1'b0;
    end else begin
      UPDATE    <= 1'b0;
      DELAY_RST <= 1'b0;
      if (bnd) pcnt <= pcnt_inc;
      case (state)
        OFF: begin
          OUTPUT_BALANCE <= BALANCE_REQ;
          if (STOP_REQ) begin
            start_pend <= 1'b0;
          end else if (START_REQ || start_pend) begin
            state          <= ARM;
            BUSY           <= 1'b1;
            DELAY_RST      <= 1'b1;
            start_pend     <= 1'b0;
            pcnt           <= '0;
            OUTPUT_BALANCE <= 1'b1;
          end
        end
        ARM: begin
          if (STOP_REQ) begin
            state          <= OFF;
            BUSY           <= 1'b0;
            pcnt           <= '0;
            OUTPUT_BALANCE <= BALANCE_REQ;
          end else if (bnd && pcnt == ARM_LAST) begin
            state          <= RUN;
            OUTPUT_EN      <= 1'b1;
            OUTPUT_BALANCE <= 1'b0;
            UPDATE         <= 1'b1;
            pcnt           <= '0;
            pending        <= 1'b0;
            stop_pend      <= 1'b0;
          end
        end
        RUN: begin
          if (STOP_REQ)   stop_pend <= 1'b1;
          if (DATA_VALID) pcnt <= '0;
          if (bnd) begin
            // A stop (pending or arriving now) or watchdog trip discards any queued update
            if (stop_pend || STOP_REQ || wdt_trip) begin
              state          <= DRAIN;
              OUTPUT_EN      <= 1'b0;
              OUTPUT_BALANCE <= 1'b1;
              pending        <= 1'b0;
              stop_pend      <= 1'b0;
              pcnt           <= '0;
            end else begin
              UPDATE  <= pending || DATA_VALID;
              pending <= 1'b0;
            end
          end else if (DATA_VALID) begin
            pending <= 1'b1;
          end
        end
        DRAIN: begin
          if (STOP_REQ)       start_pend <= 1'b0;
          else if (START_REQ) start_pend <= 1'b1;
          if (bnd && pcnt == DRAIN_LAST) begin
            state          <= OFF;
            BUSY           <= 1'b0;
            pcnt           <= '0;
            OUTPUT_BALANCE <= BALANCE_REQ;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tr_output_sequencer.sv
// Randomized + directed bench for tr_output_sequencer; pulse outputs are scoreboarded by cycle number.
module tb_tr_output_sequencer;
  localparam int CYC   = 64;
  localparam int ARM_P = 2;
  localparam int DRN_P = 4;
  localparam int WDT_P = 3;
  localparam int S_OFF = 0, S_ARM = 1, S_RUN = 2, S_DRAIN = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [8:0] TIME = '0;
  logic       START_REQ = 1'b0, STOP_REQ = 1'b0, BALANCE_REQ = 1'b0, DATA_VALID = 1'b0;
  logic       UPDATE, DELAY_RST, OUTPUT_EN, OUTPUT_BALANCE, BUSY, WDT_FLAG;
  logic [1:0] STATE;

  tr_output_sequencer #(
    .ULTRASOUND_CNT_CYCLE(CYC), .ARM_PERIODS(ARM_P),
    .DRAIN_PERIODS(DRN_P), .WDT_PERIODS(WDT_P)
  ) dut (
    .CLK(CLK), .RST(RST), .TIME(TIME), .START_REQ(START_REQ), .STOP_REQ(STOP_REQ),
    .BALANCE_REQ(BALANCE_REQ), .DATA_VALID(DATA_VALID), .UPDATE(UPDATE),
    .DELAY_RST(DELAY_RST), .OUTPUT_EN(OUTPUT_EN), .OUTPUT_BALANCE(OUTPUT_BALANCE),
    .BUSY(BUSY), .STATE(STATE), .WDT_FLAG(WDT_FLAG)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  bit armed = 0;
  int uq[$];
  int dq[$];

  // Reference model: periods remaining rather than a boundary counter
  int m_state = S_OFF;
  bit m_en = 0, m_bal = 0, m_flag = 0;
  bit pend = 0, stop_pend = 0, start_pend = 0;
  int arm_left = 0, drain_left = 0, quiet = 0;
  int tnext = 0;
  bit bq = 0;

  task automatic model_step(input bit rst, input bit s, input bit p, input bit b, input bit dv, input int t);
    bit bnd, upd, drst, trip;
    bnd = (t == CYC - 1); upd = 0; drst = 0; trip = 0;
    if (rst) begin
      m_state = S_OFF; m_en = 0; m_bal = 0; m_flag = 0;
      pend = 0; stop_pend = 0; start_pend = 0;
    end else begin
`ifdef TR_SEQ_WATCHDOG_EN
      if (s) m_flag = 0;
`endif
      case (m_state)
        S_OFF: begin
          m_bal = b;
          if (p) start_pend = 0;
          else if (s || start_pend) begin
            m_state = S_ARM; drst = 1; start_pend = 0; arm_left = ARM_P; m_bal = 1;
          end
        end
        S_ARM: begin
          if (p) begin m_state = S_OFF; m_bal = b; end
          else if (bnd) begin
            arm_left--;
            if (arm_left == 0) begin
              m_state = S_RUN; m_en = 1; m_bal = 0; upd = 1; pend = 0; stop_pend = 0; quiet = 0;
            end
          end
        end
        S_RUN: begin
          if (p) stop_pend = 1;
          if (bnd) begin
`ifdef TR_SEQ_WATCHDOG_EN
            if (!dv && quiet + 1 >= WDT_P) begin trip = 1; m_flag = 1; end
`endif
            if (stop_pend || trip) begin
              m_state = S_DRAIN; m_en = 0; m_bal = 1; pend = 0; stop_pend = 0; drain_left = DRN_P;
            end else begin
              upd = pend || dv; pend = 0;
            end
            quiet = dv ? 0 : quiet + 1;
          end else if (dv) begin
            pend = 1; quiet = 0;
          end
        end
        default: begin
          if (p) start_pend = 0;
          else if (s) start_pend = 1;
          if (bnd) begin
            drain_left--;
            if (drain_left == 0) begin m_state = S_OFF; m_bal = b; end
          end
        end
      endcase
    end
    if (upd)  uq.push_back(cyc + 1);
    if (drst) dq.push_back(cyc + 1);
  endtask

  task automatic cycle(input bit rst, input bit s, input bit p, input bit dv);
    logic [5:0] got, exp;
    @(negedge CLK);
    if (armed) begin
      got = {STATE, OUTPUT_EN, OUTPUT_BALANCE, BUSY, WDT_FLAG};
      exp = {2'(m_state), m_en, m_bal, (m_state != S_OFF), m_flag};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL levels{st,en,bal,busy,wdt} cyc=%0d got %b exp %b", cyc, got, exp);
      end
    end
    RST = rst; START_REQ = s; STOP_REQ = p; DATA_VALID = dv; BALANCE_REQ = bq;
    TIME = 9'(tnext);
    model_step(rst, s, p, bq, dv, tnext);
    tnext = (tnext + 1) % CYC;
    if (rst) armed = 1;
  endtask

  task automatic run_to(input int t);
    while (tnext != t) cycle(0, 0, 0, 0);
  endtask

  task automatic idle(input int periods);
    repeat (periods * CYC) cycle(0, 0, 0, 0);
  endtask

  // Pulse monitor: pops the expected cycle for each UPDATE / DELAY_RST pulse
  always @(negedge CLK) if (armed) begin
    while (uq.size() > 0 && uq[0] < cyc) begin
      checks++; errors++;
      $display("FAIL update_missing now=%0d expected_at=%0d", cyc, uq[0]);
      void'(uq.pop_front());
    end
    while (dq.size() > 0 && dq[0] < cyc) begin
      checks++; errors++;
      $display("FAIL delay_rst_missing now=%0d expected_at=%0d", cyc, dq[0]);
      void'(dq.pop_front());
    end
    if (UPDATE === 1'b1) begin
      checks++;
      if (uq.size() > 0 && uq[0] == cyc) void'(uq.pop_front());
      else begin errors++; $display("FAIL update_unexpected at cyc=%0d got 1 exp 0", cyc); end
    end
    if (DELAY_RST === 1'b1) begin
      checks++;
      if (dq.size() > 0 && dq[0] == cyc) void'(dq.pop_front());
      else begin errors++; $display("FAIL delay_rst_unexpected at cyc=%0d got 1 exp 0", cyc); end
    end
    if (UPDATE === 1'b1 && DELAY_RST === 1'b1) begin
      errors++; $display("FAIL update_and_delay_rst_together cyc=%0d got 11 exp not both", cyc);
    end
  end

  initial begin
    // T1: reset then start mid-period
    repeat (3) cycle(1, 0, 0, 0);
    idle(1);
    run_to(40); cycle(0, 1, 0, 0);
    idle(3);
    // T2: coalescing, then DATA_VALID exactly on the boundary
    run_to(10); cycle(0, 0, 0, 1);
    run_to(20); cycle(0, 0, 0, 1);
    run_to(50); cycle(0, 0, 0, 1);
    run_to(5);
    run_to(CYC - 1); cycle(0, 0, 0, 1);
    idle(1);
    // T3: stop and drain with BALANCE_REQ changing
    run_to(30); cycle(0, 0, 1, 0);
    idle(2); bq = 1; idle(4); bq = 0; idle(1);
    // T4: START+STOP collision in OFF, then START during DRAIN
    cycle(0, 1, 1, 0); idle(1);
    cycle(0, 1, 0, 0); idle(3);
    run_to(30); cycle(0, 0, 1, 0);
    run_to(10); cycle(0, 1, 0, 0);
    idle(9);
    // T5: reset while running, DATA_VALID after release must not update
    cycle(1, 0, 0, 0);
    run_to(20); cycle(0, 0, 0, 1);
    idle(2);
    // T6: run with no DATA_VALID (watchdog build drains), then START clears the flag
    cycle(0, 1, 0, 0);
    idle(8);
    cycle(0, 1, 0, 0);
    idle(3);
    // Random phase
    for (int i = 0; i < 30000; i++) begin
      bit r, s, p, d;
      r = ($urandom_range(0, 3999) == 0);
      s = ($urandom_range(0, 149) == 0);
      p = ($urandom_range(0, 199) == 0) && (tnext != CYC - 1);
      d = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) bq = ~bq;
      cycle(r, s, p, d);
    end
    idle(2);
    @(negedge CLK);
    checks++;
    if (uq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL pulses_outstanding got update=%0d delay_rst=%0d exp 0", uq.size(), dq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
